// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage types and constants
// Provides the fetch FSM encoding, reset PC default, word stride and j/jal target builder.
package mips_pkg;
    typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} fetch_state_t;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] WORD = 32'd4;
    function automatic logic [31:0] jump_target(input logic [3:0] hi, input logic [25:0] idx);
        return {hi, idx, 2'b00};
    endfunction
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC priority mux (jr > jump > branch > sequential) with alignment check
// Ports: stall, jr/jr_addr, jump/jump_index/pc_hi, branch_taken/branch_target, seq_pc in;
//        next_pc, redirect (honoured redirect request), misaligned out.
module pc_next_sel
    import mips_pkg::*;
(
    input  logic        stall,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic [3:0]  pc_hi,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] seq_pc,
    output logic [31:0] next_pc,
    output logic        redirect,
    output logic        misaligned
);
    assign next_pc    = jr ? jr_addr : jump ? jump_target(pc_hi, jump_index) : branch_taken ? branch_target : seq_pc;
    assign redirect   = !stall && (jr || jump || branch_taken);
    assign misaligned = next_pc[1:0] != 2'b00;
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: MIPS program counter and instruction fetch stage
// Ports: clk, rst, stall; redirects (branch/jump/jr); imem req/addr/ack/rdata handshake;
//        if_valid/if_instr/if_pc/if_pc_plus4 to decode; sticky exc_adel/exc_addr.
module pc_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        exc_adel,
    output logic [31:0] exc_addr
);
    fetch_state_t state, state_next;
    logic [31:0] pc, pend_pc, next_pc;
    logic pend, redirect, misaligned, take, bad, capture;

    pc_next_sel u_sel (
        .stall(stall), .jr(jr), .jr_addr(jr_addr), .jump(jump), .jump_index(jump_index),
        .pc_hi(if_pc_plus4[31:28]), .branch_taken(branch_taken), .branch_target(branch_target),
        .seq_pc(pc + WORD), .next_pc(next_pc), .redirect(redirect), .misaligned(misaligned)
    );

    assign imem_req  = state == REQ;
    assign imem_addr = pc;
    assign take      = redirect && state != ERR;
    assign bad       = take && misaligned;
    // A word is kept only if no redirect is pending or arriving; otherwise it belongs to a dead path.
    assign capture   = state == REQ && imem_ack && !pend && !redirect;

    always_comb begin
        state_next = state;
        state_next = bad ? ERR
                   : state == IDLE ? REQ
                   : (capture && stall) ? HOLD
                   : (state == HOLD && !stall) ? REQ
                   : state;
    end

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            pend <= 1'b0;
            pend_pc <= '0;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc <= '0;
            if_pc_plus4 <= '0;
            exc_adel <= 1'b0;
            exc_addr <= '0;
        end else if (bad) begin
            exc_adel <= 1'b1;
            exc_addr <= next_pc;
            if_valid <= 1'b0;
            pend <= 1'b0;
        end else if ((state == IDLE || state == HOLD) && !stall) begin
            if_valid <= 1'b0;
            if (take) pc <= next_pc;
        end else if (state == REQ && imem_ack && capture) begin
            if_valid <= 1'b1;
            if_instr <= imem_rdata;
            if_pc <= pc;
            if_pc_plus4 <= pc + WORD;
            pc <= next_pc;
        end else if (state == REQ && imem_ack) begin
            // Stale word: drop it and steer the next fetch to the newest target.
            if_valid <= 1'b0;
            pc <= take ? next_pc : pend_pc;
            pend <= 1'b0;
        end else if (state == REQ && take) begin
            // imem_addr must stay stable mid-fetch, so the target waits here.
            pend <= 1'b1;
            pend_pc <= next_pc;
            if_valid <= 1'b0;
        end else if (state == REQ && !stall) begin
            if_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed-vector bench for pc_fetch
module tb_pc_fetch;
    localparam logic [31:0] K = 32'hC0DE_0000;
    logic clk = 1'b0, rst = 1'b1, stall = 1'b0;
    logic branch_taken = 1'b0, jump = 1'b0, jr = 1'b0, imem_ack = 1'b0;
    logic [31:0] branch_target = '0, jr_addr = '0;
    logic [25:0] jump_index = '0;
    logic imem_req, if_valid, exc_adel;
    logic [31:0] imem_addr, imem_rdata, if_instr, if_pc, if_pc_plus4, exc_addr;
    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;
    assign imem_rdata = imem_addr ^ K;

    pc_fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index), .jr(jr), .jr_addr(jr_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
        .exc_adel(exc_adel), .exc_addr(exc_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(); step();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_exc", exc_adel, 0);
        rst = 0; imem_ack = 1;
        step();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 0);
        chk("first_valid", if_valid, 0);
        step();
        chk("seq_addr4", imem_addr, 32'h4);
        chk("seq_valid0", if_valid, 1);
        chk("seq_pc0", if_pc, 32'h0);
        chk("seq_instr0", if_instr, K);
        chk("seq_pc4_0", if_pc_plus4, 32'h4);
        step();
        chk("seq_addr8", imem_addr, 32'h8);
        chk("seq_instr4", if_instr, 32'h4 ^ K);
        stall = 1;
        step();
        chk("stall_pc", if_pc, 32'h8);
        chk("stall_req", imem_req, 0);
        chk("stall_addr", imem_addr, 32'hC);
        step(); step();
        chk("hold_pc", if_pc, 32'h8);
        chk("hold_instr", if_instr, 32'h8 ^ K);
        chk("hold_valid", if_valid, 1);
        chk("hold_req", imem_req, 0);
        stall = 0;
        step();
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, 32'hC);
        chk("resume_valid", if_valid, 0);
        step();
        chk("fetch_c", if_pc, 32'hC);
        chk("addr_10", imem_addr, 32'h10);
        imem_ack = 0; branch_taken = 1; branch_target = 32'h40;
        step();
        branch_taken = 0;
        chk("pend_addr", imem_addr, 32'h10);
        chk("pend_req", imem_req, 1);
        chk("pend_valid", if_valid, 0);
        step(); step();
        chk("pend_addr2", imem_addr, 32'h10);
        imem_ack = 1;
        step();
        chk("discard_valid", if_valid, 0);
        chk("br_addr", imem_addr, 32'h40);
        step();
        chk("br_pc", if_pc, 32'h40);
        chk("br_valid", if_valid, 1);
        jr = 1; jr_addr = 32'h100; jump = 1; jump_index = 26'h5; branch_taken = 1; branch_target = 32'h80;
        step();
        jr = 0; jump = 0; branch_taken = 0;
        chk("prio_addr", imem_addr, 32'h100);
        chk("prio_valid", if_valid, 0);
        step();
        chk("prio_pc", if_pc, 32'h100);
        jr = 1; jr_addr = 32'h1000_0000;
        step();
        jr = 0;
        step();
        chk("j_base_pc", if_pc, 32'h1000_0000);
        chk("j_base_pc4", if_pc_plus4, 32'h1000_0004);
        jump = 1; jump_index = 26'h10;
        step();
        jump = 0;
        chk("jump_addr", imem_addr, 32'h1000_0040);
        jr = 1; jr_addr = 32'hFFFF_FFFC;
        step();
        jr = 0;
        step();
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_pc_plus4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        stall = 1; jr = 1; jr_addr = 32'h200; imem_ack = 0;
        step();
        chk("ign_addr", imem_addr, 32'h0);
        chk("ign_req", imem_req, 1);
        chk("ign_valid", if_valid, 1);
        stall = 0; jr = 0; imem_ack = 1;
        step();
        chk("ign_pc", if_pc, 32'h0);
        chk("ign_next", imem_addr, 32'h4);
        jr = 1; jr_addr = 32'h102;
        step();
        jr = 0;
        chk("adel", exc_adel, 1);
        chk("adel_addr", exc_addr, 32'h102);
        chk("adel_req", imem_req, 0);
        chk("adel_valid", if_valid, 0);
        step(); step(); step();
        chk("adel_sticky", exc_adel, 1);
        chk("adel_req2", imem_req, 0);
        rst = 1;
        step();
        rst = 0; imem_ack = 0;
        step();
        chk("rec_req", imem_req, 1);
        chk("rec_addr", imem_addr, 32'h0);
        chk("rec_exc", exc_adel, 0);
        rst = 1; imem_ack = 1;
        step();
        chk("mid_rst_req", imem_req, 0);
        chk("mid_rst_valid", if_valid, 0);
        rst = 0;
        step();
        chk("mid_rst_req2", imem_req, 1);
        chk("mid_rst_addr", imem_addr, 32'h0);
        step();
        chk("mid_rst_pc", if_pc, 32'h0);
        chk("mid_rst_v", if_valid, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
